// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU memory bus arbiter and its helpers.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (see mem_bus_arbiter).
package mem_map_pkg;

    // Physical target selected by a virtual address
    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_ROM,
        TGT_KBD,
        TGT_KSTAT,
        TGT_NONE
    } mem_tgt_e;

    // Upper address byte that selects the boot ROM window
    localparam logic [7:0]  ROM_PREFIX   = 8'hFF;

    // Default keyboard data address; status lives two bytes above it
    localparam logic [15:0] KBD_ADDR_DEF = 16'hFE00;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD,
        LOCAL,
        DONE
    } arb_state_e;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational virtual address decoder: target select plus translated
// SRAM word address and ROM address. Also used by the debug monitor.
module mem_addr_decode
    import mem_map_pkg::*;
#(
    parameter logic [15:0] KBD_ADDR = KBD_ADDR_DEF
) (
    input  logic [15:0] addr,
    output mem_tgt_e    tgt,
    output logic [15:0] ram_addr,
    output logic [15:0] rom_addr
);

    localparam logic [15:0] KSTAT_ADDR = KBD_ADDR + 16'd2;

    // Keyboard addresses are checked first so a relocated KBD_ADDR always wins
    always_comb begin
        tgt = TGT_NONE;
        if (addr == KBD_ADDR)
            tgt = TGT_KBD;
        else if (addr == KSTAT_ADDR)
            tgt = TGT_KSTAT;
        else if (!addr[15])
            tgt = TGT_RAM;
        else if (addr[15:8] == ROM_PREFIX)
            tgt = TGT_ROM;
    end

    assign ram_addr = {1'b0, addr[15:1]};
    assign rom_addr = {8'h00, addr[7:0]};

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU memory bus arbiter: serialises fetch and data requests onto SRAM,
// boot ROM and keyboard port, generates SRAM strobe timing, returns read
// data with a one-cycle ack.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN -- tie-break alternates so the
// port not served last wins; otherwise data always beats fetch.
module mem_bus_arbiter
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_RD_CYCLES = 2,
    parameter int unsigned RAM_WE_CYCLES = 1,
    parameter logic [15:0] KBD_ADDR      = KBD_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_data_out,
    input  logic [15:0] ram_data_in,
    output logic        ram_data_oe,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic [15:0] kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_pop
);

    localparam logic [3:0] RD_LOAD = 4'(RAM_RD_CYCLES - 1);
    localparam logic [3:0] WE_LOAD = 4'(RAM_WE_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;       // 1 = data port granted
    logic        we_q, we_d;
    logic        bad_q, bad_d;         // unmapped or illegal write
    mem_tgt_e    tgt_q, tgt_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_data_out_q, ram_data_out_d;
    logic [15:0] rom_addr_q, rom_addr_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic        ram_data_oe_q, ram_data_oe_d;
    logic        ram_ce_n_q, ram_ce_n_d, ram_oe_n_q, ram_oe_n_d, ram_we_n_q, ram_we_n_d;
    logic        kbd_pop_q, kbd_pop_d;

    logic        pick_data;
    logic [15:0] req_addr;
    logic        req_we, req_bad;
    mem_tgt_e    dec_tgt;
    logic [15:0] dec_ram_addr, dec_rom_addr;
    logic [15:0] res;
    logic        fin;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;              // 1 = fetch wins the next tie
    assign pick_data = d_req && !(if_req && prio_q);
`else
    assign pick_data = d_req;
`endif

    assign req_addr = pick_data ? d_addr : if_addr;
    assign req_we   = pick_data && d_we;
    assign req_bad  = (dec_tgt == TGT_NONE) || (req_we && dec_tgt != TGT_RAM);

    mem_addr_decode #(.KBD_ADDR(KBD_ADDR)) u_dec (
        .addr     (req_addr),
        .tgt      (dec_tgt),
        .ram_addr (dec_ram_addr),
        .rom_addr (dec_rom_addr)
    );

    // Next-state, latched request and next registered-output computation
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        port_d         = port_q;
        we_d           = we_q;
        bad_d          = bad_q;
        tgt_d          = tgt_q;
        ram_addr_d     = ram_addr_q;
        ram_data_out_d = ram_data_out_q;
        rom_addr_d     = rom_addr_q;
        if_rdata_d     = if_rdata_q;
        d_rdata_d      = d_rdata_q;
        kbd_pop_d      = 1'b0;
        res            = 16'h0000;
        fin            = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_d         = prio_q;
`endif
        case (state_q)
            IDLE: if (d_req || if_req) begin
                port_d     = pick_data;
                we_d       = req_we;
                tgt_d      = dec_tgt;
                bad_d      = req_bad;
                ram_addr_d = dec_ram_addr;
                rom_addr_d = dec_rom_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                prio_d     = pick_data;
`endif
                if (req_bad) begin
                    state_d = LOCAL;
                end else if (dec_tgt == TGT_RAM) begin
                    if (req_we) begin
                        state_d        = WSETUP;
                        ram_data_out_d = d_wdata;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_LOAD;
                    end
                end else begin
                    state_d   = LOCAL;
                    // pop decision fixed at grant so data and pop stay consistent
                    kbd_pop_d = (dec_tgt == TGT_KBD) && kbd_valid;
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    res     = ram_data_in;
                    fin     = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WSETUP: begin
                state_d = WPULSE;
                cnt_d   = WE_LOAD;
            end
            WPULSE: begin
                if (cnt_q == 4'd0) state_d = WHOLD;
                else               cnt_d   = cnt_q - 4'd1;
            end
            WHOLD: begin
                fin     = 1'b1;
                state_d = DONE;
            end
            LOCAL: begin
                // rom_data is valid by the edge one cycle after rom_addr moved
                fin     = 1'b1;
                state_d = DONE;
                if (!bad_q) begin
                    case (tgt_q)
                        TGT_ROM:   res = rom_data;
                        TGT_KBD:   res = kbd_pop_q ? kbd_data : 16'h0000;
                        TGT_KSTAT: res = {15'b0, kbd_valid};
                        default:   res = 16'h0000;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // read data only moves on reads and errors, and only for the granted port
        if (fin && (!we_q || bad_q)) begin
            if (port_q) d_rdata_d  = res;
            else        if_rdata_d = res;
        end
        d_ack_d  = fin && port_q;
        if_ack_d = fin && !port_q;
        d_err_d  = d_ack_d && bad_q;
        if_err_d = if_ack_d && bad_q;

        // strobes follow the state being entered so they line up with it
        ram_ce_n_d    = !(state_d == RD || state_d == WSETUP ||
                          state_d == WPULSE || state_d == WHOLD);
        ram_oe_n_d    = !(state_d == RD);
        ram_we_n_d    = !(state_d == WPULSE);
        ram_data_oe_d = (state_d == WSETUP || state_d == WPULSE || state_d == WHOLD);
    end

    // All state and outputs; reset aborts any access with strobes idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            bad_q          <= 1'b0;
            tgt_q          <= TGT_NONE;
            ram_addr_q     <= 16'h0000;
            ram_data_out_q <= 16'h0000;
            rom_addr_q     <= 16'h0000;
            if_rdata_q     <= 16'h0000;
            d_rdata_q      <= 16'h0000;
            if_ack_q       <= 1'b0;
            if_err_q       <= 1'b0;
            d_ack_q        <= 1'b0;
            d_err_q        <= 1'b0;
            ram_data_oe_q  <= 1'b0;
            ram_ce_n_q     <= 1'b1;
            ram_oe_n_q     <= 1'b1;
            ram_we_n_q     <= 1'b1;
            kbd_pop_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            port_q         <= port_d;
            we_q           <= we_d;
            bad_q          <= bad_d;
            tgt_q          <= tgt_d;
            ram_addr_q     <= ram_addr_d;
            ram_data_out_q <= ram_data_out_d;
            rom_addr_q     <= rom_addr_d;
            if_rdata_q     <= if_rdata_d;
            d_rdata_q      <= d_rdata_d;
            if_ack_q       <= if_ack_d;
            if_err_q       <= if_err_d;
            d_ack_q        <= d_ack_d;
            d_err_q        <= d_err_d;
            ram_data_oe_q  <= ram_data_oe_d;
            ram_ce_n_q     <= ram_ce_n_d;
            ram_oe_n_q     <= ram_oe_n_d;
            ram_we_n_q     <= ram_we_n_d;
            kbd_pop_q      <= kbd_pop_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_q         <= prio_d;
`endif
        end
    end

    assign if_ack       = if_ack_q;
    assign if_rdata     = if_rdata_q;
    assign if_err       = if_err_q;
    assign d_ack        = d_ack_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;
    assign ram_addr     = ram_addr_q;
    assign ram_data_out = ram_data_out_q;
    assign ram_data_oe  = ram_data_oe_q;
    assign ram_ce_n     = ram_ce_n_q;
    assign ram_oe_n     = ram_oe_n_q;
    assign ram_we_n     = ram_we_n_q;
    assign rom_addr     = rom_addr_q;
    assign kbd_pop      = kbd_pop_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (RAM_RD_CYCLES=2,
// RAM_WE_CYCLES=1), plus hand sequences for arbitration and mid-write reset.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, if_err, d_ack, d_err;
    logic [15:0] if_rdata, d_rdata;
    logic [15:0] ram_addr, ram_data_out, ram_data_in, rom_addr, rom_data, kbd_data;
    logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n, kbd_valid, kbd_pop;

    logic        use_model;
    logic [15:0] ram_in_v;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // SRAM stand-in: fixed value per vector, or an address-derived pattern
    assign ram_data_in = use_model ? (ram_addr ^ 16'h5A00) : ram_in_v;

    mem_bus_arbiter #(.RAM_RD_CYCLES(2), .RAM_WE_CYCLES(1), .KBD_ADDR(16'hFE00)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_pop(kbd_pop)
    );

    typedef struct {
        bit          port_d;    // 1 = data port, 0 = fetch port
        bit          we;
        logic [15:0] addr, wdata, ram_in, rom_in, kbd_d;
        bit          kv;
        int          lat;       // edges from sampling edge to ack
        logic [15:0] rdata;
        bit          err;
        int          pop, oe, wel, doe;
        logic [15:0] raddr;
        bit          romchk;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int oe = 0, wel = 0, doe = 0, ce = 0, pop = 0, other = 0, lat = -1;
        logic [15:0] ra = 16'h0, wd = 16'h0, rd = 16'h0, rom_a = 16'h0;
        logic er = 1'b0;
        bit got = 0;
        @(posedge clk); #1;
        use_model = 1'b0;
        ram_in_v = v.ram_in; rom_data = v.rom_in; kbd_data = v.kbd_d; kbd_valid = v.kv;
        d_we = v.we; d_wdata = v.wdata;
        if (v.port_d) begin d_addr = v.addr; d_req = 1'b1; end
        else          begin if_addr = v.addr; if_req = 1'b1; end
        for (int n = 1; n <= 30 && !got; n++) begin
            @(negedge clk);
            if (!ram_oe_n) oe++;
            if (!ram_we_n) begin wel++; wd = ram_data_out; end
            if (ram_data_oe) doe++;
            if (!ram_ce_n) begin ce++; ra = ram_addr; end
            if (kbd_pop) pop++;
            if (v.port_d ? if_ack : d_ack) other++;
            if (v.port_d ? d_ack : if_ack) begin
                got = 1; lat = n - 1;
                rd = v.port_d ? d_rdata : if_rdata;
                er = v.port_d ? d_err : if_err;
                rom_a = rom_addr;
                d_req = 1'b0; if_req = 1'b0;
            end
        end
        if (!got) begin d_req = 1'b0; if_req = 1'b0; end
        check($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d rdata", idx), 32'(rd), 32'(v.rdata));
        check($sformatf("v%0d err", idx), 32'(er), 32'(v.err));
        check($sformatf("v%0d kbd_pop_cycles", idx), 32'(pop), 32'(v.pop));
        check($sformatf("v%0d oe_low_cycles", idx), 32'(oe), 32'(v.oe));
        check($sformatf("v%0d we_low_cycles", idx), 32'(wel), 32'(v.wel));
        check($sformatf("v%0d data_oe_cycles", idx), 32'(doe), 32'(v.doe));
        check($sformatf("v%0d ce_low_cycles", idx), 32'(ce), 32'(v.oe + v.doe));
        check($sformatf("v%0d other_port_ack", idx), 32'(other), 32'd0);
        if (ce > 0) check($sformatf("v%0d ram_addr", idx), 32'(ra), 32'(v.raddr));
        if (wel > 0) check($sformatf("v%0d ram_data_out", idx), 32'(wd), 32'(v.wdata));
        if (v.romchk) check($sformatf("v%0d rom_addr", idx), 32'(rom_a), 32'({8'h00, v.addr[7:0]}));
        @(posedge clk);
    endtask

    initial begin
        int dcnt, d1_t, d2_t, if_t, acks;
        bit ifgot, seen;
        logic [15:0] d_at_if, exp_d_at_if;

        //         port we addr      wdata     ram_in    rom_in    kbd_d     kv lat rdata     err pop oe we doe raddr     romchk
        vecs[0]  = '{1, 0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 0, 3, 16'hBEEF, 0, 0, 2, 0, 0, 16'h0008, 0};
        vecs[1]  = '{1, 1, 16'h0020, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 4, 16'hBEEF, 0, 0, 0, 1, 3, 16'h0010, 0};
        vecs[2]  = '{1, 0, 16'hFE00, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 1, 2, 16'h0041, 0, 1, 0, 0, 0, 16'h0000, 0};
        vecs[3]  = '{1, 0, 16'hFE00, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 0, 2, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
        vecs[4]  = '{1, 0, 16'hFE02, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 1, 2, 16'h0001, 0, 0, 0, 0, 0, 16'h0000, 0};
        vecs[5]  = '{1, 0, 16'hFE02, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 0, 2, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
        vecs[6]  = '{0, 0, 16'hFF05, 16'h0000, 16'h0000, 16'h0A0B, 16'h0000, 0, 2, 16'h0A0B, 0, 0, 0, 0, 0, 16'h0000, 1};
        vecs[7]  = '{1, 1, 16'hFF05, 16'h5555, 16'h0000, 16'h0A0B, 16'h0000, 0, 2, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0};
        vecs[8]  = '{1, 0, 16'h9000, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 0, 2, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0};
        vecs[9]  = '{0, 0, 16'h9000, 16'h0000, 16'h1111, 16'h2222, 16'h0000, 0, 2, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0};
        vecs[10] = '{1, 1, 16'hFE00, 16'h7777, 16'h0000, 16'h0000, 16'h0041, 1, 2, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0};
        vecs[11] = '{0, 0, 16'h0100, 16'h0000, 16'hCAFE, 16'h0000, 16'h0000, 0, 3, 16'hCAFE, 0, 0, 2, 0, 0, 16'h0080, 0};
        vecs[12] = '{1, 0, 16'h7FFE, 16'h0000, 16'h5A5A, 16'h0000, 16'h0000, 0, 3, 16'h5A5A, 0, 0, 2, 0, 0, 16'h3FFF, 0};
        vecs[13] = '{1, 0, 16'hFF80, 16'h0000, 16'h0000, 16'h1357, 16'h0000, 0, 2, 16'h1357, 0, 0, 0, 0, 0, 16'h0000, 1};

        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        ram_in_v = 16'h0; rom_data = 16'h0; kbd_data = 16'h0; kbd_valid = 1'b0; use_model = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst strobes ce/oe/we", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
        check("rst acks/errs/pop/doe", 32'({if_ack, if_err, d_ack, d_err, kbd_pop, ram_data_oe}), 32'h0);
        check("rst rdata", 32'({if_rdata, d_rdata}), 32'h0);
        check("rst addrs", 32'({ram_addr, rom_addr}), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // simultaneous requests; data re-requests right after its first ack
        @(posedge clk); #1;
        use_model = 1'b1; d_we = 1'b0;
        d_addr = 16'h0002; if_addr = 16'h0004; d_req = 1'b1; if_req = 1'b1;
        dcnt = 0; ifgot = 0; d1_t = -1; d2_t = -1; if_t = -1; d_at_if = 16'h0;
        for (int n = 1; n <= 60 && !(dcnt == 2 && ifgot); n++) begin
            @(negedge clk);
            if (d_ack) begin
                dcnt++;
                if (dcnt == 1) begin
                    d1_t = n; check("tie d_rdata first", 32'(d_rdata), 32'h5A01);
                    d_addr = 16'h0006;
                end else begin
                    d2_t = n; check("tie d_rdata second", 32'(d_rdata), 32'h5A03);
                    d_req = 1'b0;
                end
            end
            if (if_ack) begin
                ifgot = 1; if_t = n; d_at_if = d_rdata;
                check("tie if_rdata", 32'(if_rdata), 32'h5A02);
                check("tie if_err", 32'(if_err), 32'h0);
                if_req = 1'b0;
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        check("tie all acks seen", 32'({ifgot, 8'(dcnt)}), 32'h102);
        check("tie data acked first", 32'(d1_t > 0 && d1_t < if_t), 32'd1);
        check("tie first d_ack latency", 32'(d1_t - 1), 32'd3);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d_at_if = 16'h5A01;
        check("tie second tie grants fetch", 32'(if_t < d2_t), 32'd1);
`else
        exp_d_at_if = 16'h5A03;
        check("tie fixed priority data again", 32'(d2_t < if_t), 32'd1);
`endif
        check("tie d_rdata held at if_ack", 32'(d_at_if), 32'(exp_d_at_if));
        @(posedge clk);
        use_model = 1'b0;

        // reset asserted in the middle of the write pulse
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hA5A5; d_req = 1'b1;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (!ram_we_n) seen = 1;
        end
        check("rst-mid reached WPULSE", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst-mid strobes idle", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
        check("rst-mid data_oe off", 32'(ram_data_oe), 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        acks = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (d_ack || if_ack) acks++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (d_ack || if_ack) acks++;
        end
        check("rst-mid no ack", 32'(acks), 32'd0);
        run_vec(100, vecs[0]);
        run_vec(101, vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
